// File: rtl/arr_arb_mem.sv
// arr_arb_mem
// Single-ported on-chip array of DEPTH x WIDTH words shared by NPORTS kernel
// requesters through a round-robin arbiter. An external control port takes
// the memory over completely while controlArr is high. After reset the array
// can optionally be zeroed by a hardware clear sequence (busy high).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   controlArr               control port owns the memory while high
//   controlArrWEnable        control write strobe (else read)
//   controlArrAddr/WData     control address / write data
//   controlArrRData          control read data, registered, holds until next read
//   req/wEnable              per-port request and write(1)/read(0) select
//   addr/wData               packed per-port address / write data
//   grant                    one-hot combinational grant
//   rData                    shared registered read data for the requesters
//   rValid                   one-hot, marks the cycle rData carries port i's read
//   busy                     clear sequence in progress
module arr_arb_mem #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 16,
  parameter int NPORTS         = 2,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     controlArr,
  input  logic                     controlArrWEnable,
  input  logic [AW-1:0]            controlArrAddr,
  input  logic [WIDTH-1:0]         controlArrWData,
  output logic [WIDTH-1:0]         controlArrRData,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        wEnable,
  input  logic [NPORTS*AW-1:0]     addr,
  input  logic [NPORTS*WIDTH-1:0]  wData,
  output logic [NPORTS-1:0]        grant,
  output logic [WIDTH-1:0]         rData,
  output logic [NPORTS-1:0]        rValid,
  output logic                     busy
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state_reg;
  logic [AW-1:0]     clear_addr_reg;
  logic [PW-1:0]     rr_ptr_reg;
  logic [WIDTH-1:0]  rdata_reg;
  logic [WIDTH-1:0]  ctrl_rdata_reg;
  logic [NPORTS-1:0] rvalid_reg;

  logic [WIDTH-1:0]  mem [0:DEPTH-1];

  logic [AW-1:0]     port_addr  [NPORTS];
  logic [WIDTH-1:0]  port_wdata [NPORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_unpack
      assign port_addr[gi]  = addr[gi*AW +: AW];
      assign port_wdata[gi] = wData[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin scan: start at rr_ptr_reg, wrap, take the first requester.
  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  int            scan_idx;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    if (state_reg == ST_RUN && !controlArr) begin
      for (int off = 0; off < NPORTS; off++) begin
        scan_idx = (int'(rr_ptr_reg) + off) % NPORTS;
        if (!gnt_any && req[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(scan_idx);
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_grant
      assign grant[gi] = gnt_any && (int'(gnt_idx) == gi);
    end
  endgenerate

  // The single memory access of this cycle: clear, control, or granted port.
  logic             acc_en;
  logic             acc_we;
  logic             acc_ctrl;
  logic [AW-1:0]    acc_addr;
  logic [WIDTH-1:0] acc_wdata;
  logic             acc_in_range;

  always_comb begin
    acc_en    = 1'b0;
    acc_we    = 1'b0;
    acc_ctrl  = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    if (state_reg == ST_CLEAR) begin
      acc_en   = 1'b1;
      acc_we   = 1'b1;
      acc_addr = clear_addr_reg;
    end else if (controlArr) begin
      acc_en    = 1'b1;
      acc_we    = controlArrWEnable;
      acc_ctrl  = 1'b1;
      acc_addr  = controlArrAddr;
      acc_wdata = controlArrWData;
    end else if (gnt_any) begin
      acc_en    = 1'b1;
      acc_we    = wEnable[gnt_idx];
      acc_addr  = port_addr[gnt_idx];
      acc_wdata = port_wdata[gnt_idx];
    end
    // Nothing is committed on a reset edge.
    if (rst) begin
      acc_en = 1'b0;
    end
    acc_in_range = int'(acc_addr) < DEPTH;
  end

  // Storage has no reset; the clear sequence (if enabled) zeroes it.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we && acc_in_range) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

  // Registered read; out-of-range reads return zero but still complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg      <= '0;
      ctrl_rdata_reg <= '0;
      rvalid_reg     <= '0;
    end else begin
      rvalid_reg <= '0;
      if (acc_en && !acc_we) begin
        if (acc_ctrl) begin
          ctrl_rdata_reg <= acc_in_range ? mem[acc_addr] : '0;
        end else begin
          rdata_reg  <= acc_in_range ? mem[acc_addr] : '0;
          rvalid_reg <= grant;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clear_addr_reg <= '0;
      rr_ptr_reg     <= '0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clear_addr_reg <= clear_addr_reg + 1'b1;
          if (clear_addr_reg == AW'(DEPTH - 1)) begin
            state_reg <= ST_RUN;
          end
        end
        default: begin
          if (gnt_any) begin
            rr_ptr_reg <= (int'(gnt_idx) == NPORTS - 1) ? '0 : gnt_idx + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy            = (state_reg == ST_CLEAR);
  assign rData           = rdata_reg;
  assign controlArrRData = ctrl_rdata_reg;
  assign rValid          = rvalid_reg;

endmodule

// File: tb/tb_arr_arb_mem.sv
module tb_arr_arb_mem;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 12;
  localparam int NPORTS = 3;
  localparam int AW     = $clog2(DEPTH);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    controlArr;
  logic                    controlArrWEnable;
  logic [AW-1:0]           controlArrAddr;
  logic [WIDTH-1:0]        controlArrWData;
  logic [WIDTH-1:0]        controlArrRData;
  logic [NPORTS-1:0]       req;
  logic [NPORTS-1:0]       wEnable;
  logic [NPORTS*AW-1:0]    addr;
  logic [NPORTS*WIDTH-1:0] wData;
  logic [NPORTS-1:0]       grant;
  logic [WIDTH-1:0]        rData;
  logic [NPORTS-1:0]       rValid;
  logic                    busy;

  logic [AW-1:0]    addr_d [NPORTS];
  logic [WIDTH-1:0] wd_d   [NPORTS];

  assign addr  = {addr_d[2], addr_d[1], addr_d[0]};
  assign wData = {wd_d[2], wd_d[1], wd_d[0]};

  always #5 clk = ~clk;

  arr_arb_mem #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NPORTS(NPORTS), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .controlArr(controlArr), .controlArrWEnable(controlArrWEnable),
    .controlArrAddr(controlArrAddr), .controlArrWData(controlArrWData),
    .controlArrRData(controlArrRData),
    .req(req), .wEnable(wEnable), .addr(addr), .wData(wData),
    .grant(grant), .rData(rData), .rValid(rValid), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: memory contents, last served port, expected outputs.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               last_served;
  logic [WIDTH-1:0] exp_rd;
  logic [WIDTH-1:0] exp_crd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) ? ref_mem[a] : '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_served = NPORTS - 1;  // so port 0 is first in line
    exp_rd  = '0;
    exp_crd = '0;
  endtask

  // One RUN-state cycle with the currently driven inputs.
  task automatic do_cycle(input string tag);
    int               who;
    logic [NPORTS-1:0] exp_g;
    logic [NPORTS-1:0] exp_rv;
    #2;
    who    = -1;
    exp_g  = '0;
    exp_rv = '0;
    if (!controlArr) begin
      // Next served is the requester closest after the last one served.
      for (int k = 1; k <= NPORTS; k++) begin
        if (who < 0 && req[(last_served + k) % NPORTS]) who = (last_served + k) % NPORTS;
      end
    end
    if (who >= 0) exp_g[who] = 1'b1;
    check({tag, ":grant"}, 32'(grant), 32'(exp_g));
    if (controlArr) begin
      if (controlArrWEnable) begin
        if (int'(controlArrAddr) < DEPTH) ref_mem[controlArrAddr] = controlArrWData;
      end else begin
        exp_crd = model_read(controlArrAddr);
      end
    end else if (who >= 0) begin
      last_served = who;
      if (wEnable[who]) begin
        if (int'(addr_d[who]) < DEPTH) ref_mem[addr_d[who]] = wd_d[who];
      end else begin
        exp_rd = model_read(addr_d[who]);
        exp_rv = exp_g;
      end
    end
    tick();
    check({tag, ":rValid"}, 32'(rValid), 32'(exp_rv));
    check({tag, ":rData"}, 32'(rData), 32'(exp_rd));
    check({tag, ":ctrlRData"}, 32'(controlArrRData), 32'(exp_crd));
    $display("[TB] %s req=%b ctl=%b grant=%b rValid=%b rData=%h crd=%h",
             tag, req, controlArr, grant, rValid, rData, controlArrRData);
  endtask

  task automatic idle_inputs();
    controlArr = 0; controlArrWEnable = 0; controlArrAddr = '0; controlArrWData = '0;
    req = '0; wEnable = '0;
    for (int i = 0; i < NPORTS; i++) begin addr_d[i] = '0; wd_d[i] = '0; end
  endtask

  // Wait out the clear with all ports hammering writes; nothing may get through.
  task automatic run_clear(input string tag);
    int n;
    n = 0;
    req = '1; wEnable = '1;
    for (int i = 0; i < NPORTS; i++) begin addr_d[i] = AW'(i); wd_d[i] = 8'hFF; end
    while (busy && n < 100) begin
      n++;
      #1;
      check({tag, ":grant_in_clear"}, 32'(grant), 32'd0);
      tick();
      check({tag, ":rValid_in_clear"}, 32'(rValid), 32'd0);
    end
    check({tag, ":busy_cycles"}, 32'(n), 32'(DEPTH));
    $display("[TB] %s busy for %0d cycles", tag, n);
    idle_inputs();
  endtask

  task automatic ctrl_read_all(input string tag);
    controlArr = 1; controlArrWEnable = 0;
    req = '1; wEnable = '0;
    for (int i = 0; i < DEPTH; i++) begin
      controlArrAddr = AW'(i);
      do_cycle(tag);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    tick(); tick();
    rst = 0;
    check("reset:busy", 32'(busy), 32'd1);
    check("reset:rValid", 32'(rValid), 32'd0);
    check("reset:rData", 32'(rData), 32'd0);
    check("reset:ctrlRData", 32'(controlArrRData), 32'd0);
    run_clear("clear1");
    ctrl_read_all("clear1_read");

    // Single port write then read.
    req = 3'b001; wEnable = 3'b001; addr_d[0] = 4'd3; wd_d[0] = 8'hA5;
    do_cycle("p0_write");
    wEnable = 3'b000;
    do_cycle("p0_read");
    check("p0_read_value", 32'(rData), 32'hA5);

    // Preload distinct words, then all three ports read continuously.
    for (int i = 0; i < NPORTS; i++) begin
      idle_inputs();
      req[i] = 1'b1; wEnable[i] = 1'b1; addr_d[i] = AW'(i + 1); wd_d[i] = 8'h5A + 8'(i);
      do_cycle("preload");
    end
    idle_inputs();
    req = 3'b111;
    for (int i = 0; i < NPORTS; i++) addr_d[i] = AW'(i + 1);
    for (int c = 0; c < 6; c++) do_cycle("round_robin");

    // Control override with requesters active, then port1 observes the write.
    controlArr = 1; controlArrWEnable = 1; controlArrAddr = 4'd7; controlArrWData = 8'h3C;
    req = 3'b011;
    do_cycle("ctrl_write");
    idle_inputs();
    req = 3'b010; addr_d[1] = 4'd7;
    do_cycle("p1_read_ctrl_data");
    check("p1_sees_3C", 32'(rData), 32'h3C);

    // Out of range write/read, plus aliasing check on address 1.
    idle_inputs();
    req = 3'b001; wEnable = 3'b001; addr_d[0] = 4'd13; wd_d[0] = 8'hFF;
    do_cycle("oor_write");
    wEnable = 3'b000;
    do_cycle("oor_read");
    check("oor_read_zero", 32'(rData), 32'h0);
    addr_d[0] = 4'd1;
    do_cycle("alias_read");
    check("alias_addr1", 32'(rData), 32'h5A);
    idle_inputs();
    controlArr = 1; controlArrAddr = 4'd15;
    do_cycle("ctrl_oor_read");

    // Randomised traffic.
    for (int c = 0; c < 300; c++) begin
      controlArr        = ($urandom_range(7) == 0);
      controlArrWEnable = $urandom_range(1);
      controlArrAddr    = AW'($urandom_range(15));
      controlArrWData   = WIDTH'($urandom);
      req               = NPORTS'($urandom);
      wEnable           = NPORTS'($urandom);
      for (int i = 0; i < NPORTS; i++) begin
        addr_d[i] = AW'($urandom_range(15));
        wd_d[i]   = WIDTH'($urandom);
      end
      do_cycle("random");
    end

    // Reset arriving at the edge that would capture a granted read.
    idle_inputs();
    req = 3'b001; addr_d[0] = 4'd2;
    rst = 1;
    tick();
    rst = 0;
    model_reset();
    check("midrst:rValid", 32'(rValid), 32'd0);
    check("midrst:busy", 32'(busy), 32'd1);
    check("midrst:rData", 32'(rData), 32'd0);
    run_clear("clear2");
    ctrl_read_all("clear2_read");
    req = 3'b111;
    do_cycle("ptr_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
